// File: rtl/abc_pkg.sv
// Shared definitions for the A/B/C stimulus generator and the sequence detectors it drives.
// This package holds the FSM state codes, the symbol codes and the symbol-to-line decode.
package abc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SYM_NONE = 2'b00,
        SYM_A    = 2'b01,
        SYM_B    = 2'b10,
        SYM_C    = 2'b11
    } sym_t;

    // Returns {A,B,C}; at most one line is ever high.
    function automatic logic [2:0] sym_to_abc(input logic [1:0] code);
        logic [2:0] abc;
        abc = 3'b000;
        case (code)
            SYM_A:   abc = 3'b100;
            SYM_B:   abc = 3'b010;
            SYM_C:   abc = 3'b001;
            default: abc = 3'b000;
        endcase
        return abc;
    endfunction

endpackage

// File: rtl/abc_hold_timer.sv
// Loadable down-counter. zero flags a count of zero. When load and en are both high, load wins.
// It is used for per-symbol hold timing here and for detector timeouts elsewhere.
module abc_hold_timer #(
    parameter int HOLD_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [HOLD_W-1:0] load_val,
    input  logic              en,
    output logic              zero
);

    logic [HOLD_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= count - HOLD_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/abc_seq_gen.sv
// Programmable A/B/C stimulus transmitter. It captures a packed symbol sequence on start.
// It drives each symbol for a programmable hold time, then pulses done (or aborted if cancelled).
module abc_seq_gen
    import abc_pkg::*;
#(
    parameter int MAX_SYM = 8,
    parameter int HOLD_W  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [$clog2(MAX_SYM):0]   seq_len,
    input  logic [2*MAX_SYM-1:0]       seq_data,
    input  logic [HOLD_W-1:0]          hold,
    output logic                       A,
    output logic                       B,
    output logic                       C,
    output logic                       busy,
    output logic                       done,
    output logic                       aborted,
    output logic [$clog2(MAX_SYM)-1:0] sym_idx,
    output logic [1:0]                 state
);

    localparam int IDX_W = $clog2(MAX_SYM);
    localparam int LEN_W = IDX_W + 1;

    state_t               state_q;
    logic [2:0]           abc_q;
    logic [2*MAX_SYM-1:0] shift_q;
    logic [LEN_W-1:0]     len_q;
    logic [HOLD_W-1:0]    hold_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 aborted_q;

    logic [LEN_W-1:0]  len_eff;
    logic [HOLD_W-1:0] hold_m1;
    logic              last_sym;
    logic              timer_load;
    logic [HOLD_W-1:0] timer_load_val;
    logic              timer_en;
    logic              timer_zero;

    // A hold of 0 behaves like 1; the timer counts hold_eff-1 down to 0.
    assign len_eff  = (seq_len > LEN_W'(MAX_SYM)) ? LEN_W'(MAX_SYM) : seq_len;
    assign hold_m1  = (hold == '0) ? '0 : hold - HOLD_W'(1);
    assign last_sym = ({1'b0, idx_q} == len_q - LEN_W'(1));

    assign timer_load = ((state_q == IDLE) && start && (len_eff != '0)) ||
                        ((state_q == DRIVE) && !abort && timer_zero && !last_sym);
    assign timer_load_val = (state_q == IDLE) ? hold_m1 : hold_q;
    assign timer_en       = (state_q == DRIVE) && !timer_zero;

    abc_hold_timer #(.HOLD_W(HOLD_W)) u_hold_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_load_val),
        .en       (timer_en),
        .zero     (timer_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            abc_q     <= 3'b000;
            shift_q   <= '0;
            len_q     <= '0;
            hold_q    <= '0;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            // NOTE: pulses default low here, so any branch that sets them yields exactly one cycle.
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shift_q <= seq_data;
                        len_q   <= len_eff;
                        hold_q  <= hold_m1;
                        idx_q   <= '0;
                        if (len_eff == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= DRIVE;
                            busy_q  <= 1'b1;
                            abc_q   <= sym_to_abc(seq_data[1:0]);
                        end
                    end
                end
                DRIVE: begin
                    if (abort) begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        abc_q     <= 3'b000;
                        aborted_q <= 1'b1;
                    end else if (timer_zero) begin
                        if (last_sym) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            abc_q   <= 3'b000;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q   <= idx_q + IDX_W'(1);
                            shift_q <= shift_q >> 2;
                            abc_q   <= sym_to_abc(shift_q[3:2]);
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign {A, B, C} = abc_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign sym_idx   = idx_q;
    assign state     = state_q;

endmodule

// File: tb/tb_abc_seq_gen.sv
// Scoreboard bench for abc_seq_gen. Stimulus pushes the expected per-cycle outputs.
// A negedge monitor pops them whenever busy, done or aborted is high.
module tb_abc_seq_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [3:0]  seq_len;
    logic [15:0] seq_data;
    logic [3:0]  hold;
    logic        A, B, C, busy, done, aborted;
    logic [2:0]  sym_idx;
    logic [1:0]  state;

    typedef struct packed {
        logic [2:0] abc;
        logic [2:0] idx;
        logic [1:0] st;
        logic       bsy;
        logic       dn;
        logic       ab;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_err  = 0;
    bit   mon_en = 1'b0;

    abc_seq_gen #(.MAX_SYM(8), .HOLD_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .seq_len  (seq_len),
        .seq_data (seq_data),
        .hold     (hold),
        .A        (A),
        .B        (B),
        .C        (C),
        .busy     (busy),
        .done     (done),
        .aborted  (aborted),
        .sym_idx  (sym_idx),
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [2:0] exp_abc(input logic [1:0] code);
        case (code)
            2'b01:   return 3'b100;
            2'b10:   return 3'b010;
            2'b11:   return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    task automatic push_sym(input logic [2:0] abc, input logic [2:0] idx);
        sb.push_back('{abc: abc, idx: idx, st: 2'd1, bsy: 1'b1, dn: 1'b0, ab: 1'b0});
    endtask

    task automatic push_done();
        sb.push_back('{abc: 3'b000, idx: 3'd0, st: 2'd2, bsy: 1'b0, dn: 1'b1, ab: 1'b0});
    endtask

    task automatic push_abort();
        sb.push_back('{abc: 3'b000, idx: 3'd0, st: 2'd0, bsy: 1'b0, dn: 1'b0, ab: 1'b1});
    endtask

    // Monitor: every presented output cycle must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t got;
        exp_t e;
        if (mon_en) begin
            if (busy || done || aborted) begin
                got = '{abc: {A, B, C}, idx: (busy ? sym_idx : 3'd0), st: state,
                        bsy: busy, dn: done, ab: aborted};
                if (sb.size() == 0) begin
                    check("unexpected_output", 32'(got), 32'h0);
                end else begin
                    e = sb.pop_front();
                    check("scoreboard", 32'(got), 32'(e));
                end
            end else begin
                check("idle_abc", 32'({A, B, C}), 32'h0);
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_drain();
        int cyc = 0;
        bit ok  = 1'b0;
        while (cyc < 500) begin
            if (sb.size() == 0 && state == 2'd0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        if (!ok) begin
            check("drain_timeout", 32'(sb.size()), 32'h0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] d;
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        seq_len = '0; seq_data = '0; hold = '0;
        repeat (3) @(negedge clk);
        check("rst_state",   32'(state),     32'h0);
        check("rst_abc",     32'({A, B, C}), 32'h0);
        check("rst_busy",    32'(busy),      32'h0);
        check("rst_done",    32'(done),      32'h0);
        check("rst_aborted", 32'(aborted),   32'h0);
        check("rst_idx",     32'(sym_idx),   32'h0);
        rst = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // Basic: A,B,C each for 2 cycles, then done.
        seq_len = 4'd3; seq_data = 16'h0039; hold = 4'd2;
        push_sym(3'b100, 3'd0); push_sym(3'b100, 3'd0);
        push_sym(3'b010, 3'd1); push_sym(3'b010, 3'd1);
        push_sym(3'b001, 3'd2); push_sym(3'b001, 3'd2);
        push_done();
        pulse_start();
        wait_drain();

        // Hold 0 acts as 1; the none symbol still occupies a slot.
        seq_len = 4'd4; seq_data = 16'h0071; hold = 4'd0;
        push_sym(3'b100, 3'd0); push_sym(3'b000, 3'd1);
        push_sym(3'b001, 3'd2); push_sym(3'b100, 3'd3);
        push_done();
        pulse_start();
        wait_drain();

        // Zero length: straight to DONE.
        seq_len = 4'd0; seq_data = 16'hFFFF; hold = 4'd3;
        push_done();
        pulse_start();
        wait_drain();

        // Oversize length saturates to 8 symbols.
        seq_len = 4'd15; seq_data = 16'hE4E4; hold = 4'd1;
        d = 16'hE4E4;
        for (int i = 0; i < 8; i++) push_sym(exp_abc(d[2*i +: 2]), 3'(i));
        push_done();
        pulse_start();
        wait_drain();

        // Abort on the 2nd cycle of symbol 2 with hold 3.
        seq_len = 4'd4; seq_data = 16'h0039; hold = 4'd3;
        for (int i = 0; i < 3; i++) push_sym(3'b100, 3'd0);
        for (int i = 0; i < 3; i++) push_sym(3'b010, 3'd1);
        push_sym(3'b001, 3'd2); push_sym(3'b001, 3'd2);
        push_abort();
        pulse_start();
        repeat (7) @(negedge clk);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        wait_drain();

        // Fresh start restarts at symbol 0; abort together with start is overridden.
        seq_len = 4'd2; hold = 4'd1;
        push_sym(3'b100, 3'd0); push_sym(3'b010, 3'd1);
        push_done();
        @(negedge clk) begin start = 1'b1; abort = 1'b1; end
        @(negedge clk) begin start = 1'b0; abort = 1'b0; end
        wait_drain();

        // Back-to-back with held start; the seq_data change lands on the second run.
        seq_len = 4'd1; hold = 4'd1; seq_data = 16'h0001;
        push_sym(3'b100, 3'd0); push_done();
        push_sym(3'b010, 3'd0); push_done();
        @(negedge clk) start = 1'b1;
        @(negedge clk) seq_data = 16'h0002;
        @(negedge clk);
        @(negedge clk);
        check("b2b_idle_gap", 32'(state), 32'h0);
        @(negedge clk) start = 1'b0;
        wait_drain();

        // Reset asserted during symbol 1.
        seq_len = 4'd3; seq_data = 16'h0039; hold = 4'd2;
        push_sym(3'b100, 3'd0); push_sym(3'b100, 3'd0); push_sym(3'b010, 3'd1);
        pulse_start();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_state",   32'(state),     32'h0);
        check("midrst_abc",     32'({A, B, C}), 32'h0);
        check("midrst_busy",    32'(busy),      32'h0);
        check("midrst_done",    32'(done),      32'h0);
        check("midrst_aborted", 32'(aborted),   32'h0);
        check("midrst_sb",      32'(sb.size()), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check("postrst_done",    32'(done),    32'h0);
        check("postrst_aborted", 32'(aborted), 32'h0);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
